// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dbidec_8.sv
`default_nettype none
// ============================================================================
//  Module      : gf180mcu_fd_sc_mcu7t5v0__dbidec_8
//  Description : Data-bus-inversion decoder with a 2-entry skid buffer.
//                Each accepted bus word is un-inverted according to its
//                active-low DBI flag, checked against the transmitter's
//                inversion rule (invert iff the original word has more than
//                WIDTH/2 zero bits), and queued as {Q, ERR}. A saturating
//                counter tracks how many accepted words arrived inverted.
//
//  Ports       : CLK   - clock, rising edge
//                RN    - asynchronous reset, active-low
//                D     - bus word as transmitted (WIDTH bits)
//                DBIN  - DBI flag, 0 = D is inverted
//                IV/IR - input valid / input ready
//                Q     - decoded word at buffer head (registered)
//                ERR   - encoding-rule violation flag of head word
//                OV/OR - output valid / output ready
//                CLR   - synchronous clear of CNT
//                CNT   - saturating count of accepted inverted words
//
//  Revision    : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__dbidec_8 #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] D,
    input  logic             DBIN,
    input  logic             IV,
    output logic             IR,
    output logic [WIDTH-1:0] Q,
    output logic             ERR,
    output logic             OV,
    input  logic             OR,
    input  logic             CLR,
    output logic [CW-1:0]    CNT
);

    // Width wide enough to hold a zero count of 0..WIDTH.
    localparam int              c_ZW      = $clog2(WIDTH + 1);
    localparam logic [c_ZW-1:0] c_HALF    = c_ZW'(WIDTH / 2);
    localparam logic [CW-1:0]   c_CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0]   c_CNT_ONE = CW'(1);

    // Buffer occupancy states.
    localparam logic [1:0] c_S_EMPTY = 2'd0;
    localparam logic [1:0] c_S_ONE   = 2'd1;
    localparam logic [1:0] c_S_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic             w_push;
    logic             w_pop;

    logic [WIDTH-1:0] w_dec;
    logic [c_ZW-1:0]  w_zeros;
    logic             w_err;

    // Entry 0 is the head and drives the outputs directly; entry 1 is the
    // skid slot used only while the buffer is FULL.
    logic [WIDTH-1:0] r_head_q;
    logic             r_head_err;
    logic [WIDTH-1:0] r_tail_q;
    logic             r_tail_err;

    logic [CW-1:0]    r_cnt;

    // ------------------------------------------------------------------
    // Handshake: ready and valid come from the state register only, so
    // there is no combinational path from IV/OR to IR/OV.
    // ------------------------------------------------------------------
    assign IR     = (r_state != c_S_FULL);
    assign OV     = (r_state != c_S_EMPTY);
    assign w_push = IV & IR;
    assign w_pop  = OV & OR;

    // ------------------------------------------------------------------
    // Decode and rule check
    // ------------------------------------------------------------------
    assign w_dec = DBIN ? D : ~D;

    always_comb begin
        w_zeros = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_zeros = w_zeros + c_ZW'(~w_dec[i]);
        end
    end

    // A non-inverted word must not have a zero majority; an inverted word
    // must have had one before inversion.
    assign w_err = DBIN ? (w_zeros > c_HALF) : (w_zeros <= c_HALF);

    // ------------------------------------------------------------------
    // Occupancy state machine
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= c_S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = c_S_ONE;
                end
            end
            c_S_ONE: begin
                if (w_push && !w_pop) begin
                    w_state_nxt = c_S_FULL;
                end else if (w_pop && !w_push) begin
                    w_state_nxt = c_S_EMPTY;
                end
            end
            c_S_FULL: begin
                // IR is low here, so a pop is the only possible event.
                if (w_pop) begin
                    w_state_nxt = c_S_ONE;
                end
            end
            default: begin
                w_state_nxt = c_S_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Buffer storage
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_head_q   <= '0;
            r_head_err <= 1'b0;
            r_tail_q   <= '0;
            r_tail_err <= 1'b0;
        end else begin
            case (r_state)
                c_S_EMPTY: begin
                    if (w_push) begin
                        r_head_q   <= w_dec;
                        r_head_err <= w_err;
                    end
                end
                c_S_ONE: begin
                    if (w_push && w_pop) begin
                        // Head leaves and the new word takes its place.
                        r_head_q   <= w_dec;
                        r_head_err <= w_err;
                    end else if (w_push) begin
                        r_tail_q   <= w_dec;
                        r_tail_err <= w_err;
                    end
                end
                c_S_FULL: begin
                    if (w_pop) begin
                        r_head_q   <= r_tail_q;
                        r_head_err <= r_tail_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Q   = r_head_q;
    assign ERR = r_head_err;

    // ------------------------------------------------------------------
    // Inverted-word counter: clear wins over increment, saturates at max.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_cnt <= '0;
        end else if (CLR) begin
            r_cnt <= '0;
        end else if (w_push && !DBIN && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    assign CNT = r_cnt;

endmodule
`default_nettype wire
